sub_rr_arbiter: RTL

Round-robin arbiter that shares a single SUB-style processing unit among NREQ requesters. It grants exclusive ownership with a registered one-hot grant and holds the grant until the owner releases. A hold-limit watchdog revokes a grant that is held too long. It sits between the requesting logic in TOP and the shared sub-unit's input mux. It drives the mux select (OWNER) and the unit enable (BUSY).

---
 rtl/sub_arb_pkg.sv | 42 ++++
 rtl/sub_rr_pick.sv | 26 ++
 rtl/sub_rr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/sub_arb_pkg.sv
// Shared types and helpers for the SUB-unit round-robin arbiters.
// rr_pick works on a fixed maximum width so arbiters of any size up to NREQ_MAX can reuse it.
package sub_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RECOVER
  } arb_state_e;

  localparam int unsigned NREQ_DEF     = 4;
  localparam int unsigned MAX_HOLD_DEF = 15;
  localparam int unsigned NREQ_MAX     = 8;
  localparam int unsigned IDX_MAX_W    = 3;
  localparam int unsigned PICK_W       = IDX_MAX_W + 1;

  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] idx;
  } pick_t;

  // First asserted bit at or above ptr, wrapping at n; ptr must be below n.
  function automatic pick_t rr_pick(input logic [NREQ_MAX-1:0]  req,
                                    input logic [IDX_MAX_W-1:0] ptr,
                                    input int unsigned          n);
    pick_t             res;
    logic [PICK_W-1:0] pos;
    res = '0;
    for (int unsigned k = 0; k < NREQ_MAX; k++) begin
      pos = {1'b0, ptr} + PICK_W'(k);
      if (pos >= PICK_W'(n)) begin
        pos = pos - PICK_W'(n);
      end
      if (k < n && !res.valid && req[pos[IDX_MAX_W-1:0]]) begin
        res.valid = 1'b1;
        res.idx   = pos[IDX_MAX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sub_rr_pick.sv
// Combinational rotate-priority encoder: picks the first requester at or after ptr.
module sub_rr_pick
  import sub_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] idx
);

  logic [NREQ_MAX-1:0]  req_ext;
  logic [IDX_MAX_W-1:0] ptr_ext;
  pick_t                pick;

  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
    ptr_ext            = IDX_MAX_W'(ptr);
    pick               = rr_pick(req_ext, ptr_ext, NREQ);
    valid              = pick.valid;
    idx                = $clog2(NREQ)'(pick.idx);
  end

endmodule

// File: rtl/sub_rr_arbiter.sv
// Round-robin owner arbiter for the shared SUB unit: registered one-hot grant,
// held until release or owner request drop, with a hold-limit watchdog.
module sub_rr_arbiter
  import sub_arb_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         REQ,
  input  logic                    RELEASE,
  output logic [NREQ-1:0]         GNT,
  output logic [$clog2(NREQ)-1:0] OWNER,
  output logic                    BUSY,
  output logic                    TIMEOUT
);

  localparam int unsigned IDX_W  = $clog2(NREQ);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;

  sub_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE, RECOVER: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = NREQ'(1) << pick_idx;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          // hold counts GRANT cycles including the current one
          hold_d  = HOLD_W'(1);
          ptr_d   = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (RELEASE || !REQ[owner_q]) begin
          state_d = RECOVER;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (hold_q == HOLD_W'(MAX_HOLD)) begin
          state_d   = RECOVER;
          gnt_d     = '0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      hold_q    <= '0;
      gnt_q     <= '0;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign GNT     = gnt_q;
  assign OWNER   = owner_q;
  assign BUSY    = busy_q;
  assign TIMEOUT = timeout_q;

endmodule
